// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time, drives registered operands
// to an external combinational 4-bit ALU, waits a programmable number of
// settle edges, then samples the result and flags into a response.
// An accumulator holds the last sampled result and can replace operand A.
// Flag inconsistencies (Z or P disagreeing with the result) mark the
// response as erroneous and bump a saturating error counter.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  ACC_INIT      = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_acc,
  output logic [3:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_p,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_out,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic [3:0] acc,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter load value: the sample happens on the edge where the counter
  // reaches zero, so loading N-1 yields exactly N edges of settling.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg;
  logic [3:0] alu_opcode_reg, alu_a_reg, alu_b_reg;
  logic [3:0] rsp_out_reg, rsp_flags_reg;
  logic       rsp_err_reg;
  logic [3:0] acc_reg;
  logic [7:0] err_count_reg;

  logic accept;
  logic sample;
  logic flag_err;

  assign accept = cmd_valid && (state_reg == IDLE);
  assign sample = (state_reg == WAIT) && (cnt_reg == 4'd0);

  // Parity flag must equal the XOR of the result bits and the zero flag
  // must reflect a zero result; either mismatch marks the response bad.
  assign flag_err = (alu_p != (^alu_out)) || (alu_z != (alu_out == 4'h0));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, settle in WAIT, handshake in RESP
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid)  state_next = WAIT;
      WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    cmd_ready = (state_reg == IDLE);
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg != IDLE);
  end

  // Datapath: operand capture, settle countdown, and result sampling.
  // Operands and payload only move on accept/sample edges, so they hold
  // naturally through WAIT, RESP back-pressure and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg        <= 4'd0;
      alu_opcode_reg <= 4'h0;
      alu_a_reg      <= 4'h0;
      alu_b_reg      <= 4'h0;
      rsp_out_reg    <= 4'h0;
      rsp_flags_reg  <= 4'h0;
      rsp_err_reg    <= 1'b0;
      acc_reg        <= ACC_INIT;
      err_count_reg  <= 8'h00;
    end else begin
      if (accept) begin
        alu_opcode_reg <= cmd_opcode;
        alu_b_reg      <= cmd_b;
        alu_a_reg      <= cmd_acc ? acc_reg : cmd_a;
        cnt_reg        <= SETTLE_LOAD;
      end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (sample) begin
        rsp_out_reg   <= alu_out;
        rsp_flags_reg <= {alu_z, alu_c, alu_v, alu_p};
        rsp_err_reg   <= flag_err;
        acc_reg       <= alu_out;
        if (flag_err && (err_count_reg != 8'hFF)) begin
          err_count_reg <= err_count_reg + 8'd1;
        end
      end
    end
  end

  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign rsp_out    = rsp_out_reg;
  assign rsp_flags  = rsp_flags_reg;
  assign rsp_err    = rsp_err_reg;
  assign acc        = acc_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. Two instances: d1 (one settle edge,
// non-zero accumulator init) carries most traffic; d3 (three settle edges)
// exercises long settling, response back-pressure and ignored commands.
// The bench itself plays the external ALU by driving hand-chosen results.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd_opcode, cmd_a, cmd_b;
  logic       cmd_acc;
  logic [3:0] alu_out_i;
  logic       alu_z_i, alu_c_i, alu_v_i, alu_p_i;

  logic       cv1, rr1, cv3, rr3;

  logic       d1_cmd_ready, d1_rsp_valid, d1_rsp_err, d1_busy;
  logic [3:0] d1_alu_opcode, d1_alu_a, d1_alu_b, d1_rsp_out, d1_rsp_flags, d1_acc;
  logic [7:0] d1_err_count;

  logic       d3_cmd_ready, d3_rsp_valid, d3_rsp_err, d3_busy;
  logic [3:0] d3_alu_opcode, d3_alu_a, d3_alu_b, d3_rsp_out, d3_rsp_flags, d3_acc;
  logic [7:0] d3_err_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = 8'h00;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(1), .ACC_INIT(4'h9)) d1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cv1), .cmd_ready(d1_cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_opcode(d1_alu_opcode), .alu_a(d1_alu_a), .alu_b(d1_alu_b),
    .alu_out(alu_out_i), .alu_z(alu_z_i), .alu_c(alu_c_i), .alu_v(alu_v_i), .alu_p(alu_p_i),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rr1),
    .rsp_out(d1_rsp_out), .rsp_flags(d1_rsp_flags), .rsp_err(d1_rsp_err),
    .acc(d1_acc), .err_count(d1_err_count), .busy(d1_busy)
  );

  alu_sequencer #(.SETTLE_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cv3), .cmd_ready(d3_cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_opcode(d3_alu_opcode), .alu_a(d3_alu_a), .alu_b(d3_alu_b),
    .alu_out(alu_out_i), .alu_z(alu_z_i), .alu_c(alu_c_i), .alu_v(alu_v_i), .alu_p(alu_p_i),
    .rsp_valid(d3_rsp_valid), .rsp_ready(rr3),
    .rsp_out(d3_rsp_out), .rsp_flags(d3_rsp_flags), .rsp_err(d3_rsp_err),
    .acc(d3_acc), .err_count(d3_err_count), .busy(d3_busy)
  );

  // Single comparison point: counts every check, reports any mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction on d1. Called just after a falling edge.
  // flags is {Z,C,V,P}; exp_a and exp_e are hand-computed by the caller.
  task automatic issue1(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic ca, input logic [3:0] exp_a,
                        input logic [3:0] out, input logic [3:0] flags, input logic exp_e);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_acc = ca; cv1 = 1'b1;
    alu_out_i = out;
    {alu_z_i, alu_c_i, alu_v_i, alu_p_i} = flags;
    @(negedge clk);
    cv1 = 1'b0;
    check("wait_busy",     d1_busy, 1'b1);
    check("wait_cmdready", d1_cmd_ready, 1'b0);
    check("wait_rspvalid", d1_rsp_valid, 1'b0);
    check("alu_opcode",    d1_alu_opcode, op);
    check("alu_a",         d1_alu_a, exp_a);
    check("alu_b",         d1_alu_b, b);
    @(negedge clk);
    check("rsp_valid",     d1_rsp_valid, 1'b1);
    check("rsp_out",       d1_rsp_out, out);
    check("rsp_flags",     d1_rsp_flags, flags);
    check("rsp_err",       d1_rsp_err, exp_e);
    if (exp_e && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    check("err_count",     d1_err_count, exp_cnt);
    check("acc",           d1_acc, out);
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    check("idle_rspvalid", d1_rsp_valid, 1'b0);
    check("idle_cmdready", d1_cmd_ready, 1'b1);
    check("idle_rsp_hold", d1_rsp_out, out);
    $display("txn d1 op=%h a=%h b=%h acc_sel=%0d -> out=%h flags=%b err=%0d err_count=%0d",
             op, a, b, ca, d1_rsp_out, d1_rsp_flags, d1_rsp_err, d1_err_count);
  endtask

  initial begin
    rst_n = 1'b0; cv1 = 1'b0; rr1 = 1'b0; cv3 = 1'b0; rr3 = 1'b0;
    cmd_opcode = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_acc = 1'b0;
    alu_out_i = 4'h0; alu_z_i = 1'b0; alu_c_i = 1'b0; alu_v_i = 1'b0; alu_p_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmdready", d1_cmd_ready, 1'b1);
    check("rst_rspvalid", d1_rsp_valid, 1'b0);
    check("rst_busy",     d1_busy, 1'b0);
    check("rst_acc",      d1_acc, 4'h9);
    check("rst_errcnt",   d1_err_count, 8'h00);
    check("rst_alu_a",    d1_alu_a, 4'h0);
    check("rst_flags",    d1_rsp_flags, 4'h0);
    check("rst_d3_acc",   d3_acc, 4'h0);
    rst_n = 1'b1;

    // 2+3 with carry flag set, consistent Z/P
    issue1(4'h4, 4'h2, 4'h3, 1'b0, 4'h2, 4'h5, 4'b0100, 1'b0);
    // Accumulator as A: cmd_a=F ignored; ALU gives 7 with P=0 -> parity error
    issue1(4'h1, 4'hF, 4'h1, 1'b1, 4'h5, 4'h7, 4'b0000, 1'b1);
    // Zero result with Z=0 -> error
    issue1(4'h2, 4'h3, 4'h3, 1'b0, 4'h3, 4'h0, 4'b0000, 1'b1);
    // Zero result with Z=1, P=0 -> clean
    issue1(4'h2, 4'h6, 4'h6, 1'b0, 4'h6, 4'h0, 4'b1000, 1'b0);
    // Drive the error counter well past saturation
    for (int i = 0; i < 260; i++) begin
      issue1(4'h1, 4'h1, 4'h6, 1'b0, 4'h1, 4'h7, 4'b0000, 1'b1);
    end
    check("errcnt_sat", d1_err_count, 8'hFF);

    // Reset on the sample edge of an in-flight command
    cmd_opcode = 4'h4; cmd_a = 4'h1; cmd_b = 4'h1; cmd_acc = 1'b0; cv1 = 1'b1;
    alu_out_i = 4'h2; {alu_z_i, alu_c_i, alu_v_i, alu_p_i} = 4'b0001;
    @(negedge clk);
    cv1 = 1'b0;
    check("rw_busy", d1_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    check("rw_cmdready", d1_cmd_ready, 1'b1);
    check("rw_busy0",    d1_busy, 1'b0);
    check("rw_acc",      d1_acc, 4'h9);
    check("rw_errcnt",   d1_err_count, 8'h00);
    check("rw_rspout",   d1_rsp_out, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("rw_no_rsp", d1_rsp_valid, 1'b0);
      @(negedge clk);
    end
    // First command after reset with cmd_acc uses ACC_INIT
    issue1(4'h3, 4'h0, 4'h2, 1'b1, 4'h9, 4'hB, 4'b0001, 1'b0);

    // d3: three settle edges, held back-pressure, ignored second command
    cmd_opcode = 4'h2; cmd_a = 4'h1; cmd_b = 4'h1; cmd_acc = 1'b0; cv3 = 1'b1;
    alu_out_i = 4'h2; {alu_z_i, alu_c_i, alu_v_i, alu_p_i} = 4'b0001;
    @(negedge clk);
    cmd_a = 4'hC; cmd_opcode = 4'h7;
    for (int i = 0; i < 2; i++) begin
      check("d3_settle_valid", d3_rsp_valid, 1'b0);
      check("d3_settle_busy",  d3_busy, 1'b1);
      @(negedge clk);
    end
    check("d3_settle_valid", d3_rsp_valid, 1'b0);
    @(negedge clk);
    check("d3_sample_valid", d3_rsp_valid, 1'b1);
    alu_out_i = 4'hF; {alu_z_i, alu_c_i, alu_v_i, alu_p_i} = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      check("d3_hold_valid", d3_rsp_valid, 1'b1);
      check("d3_hold_out",   d3_rsp_out, 4'h2);
      check("d3_hold_flags", d3_rsp_flags, 4'b0001);
      check("d3_hold_err",   d3_rsp_err, 1'b0);
      check("d3_cmdready",   d3_cmd_ready, 1'b0);
      check("d3_alu_a",      d3_alu_a, 4'h1);
      check("d3_alu_op",     d3_alu_opcode, 4'h2);
      @(negedge clk);
    end
    cv3 = 1'b0; rr3 = 1'b1;
    @(negedge clk);
    rr3 = 1'b0;
    check("d3_idle_ready", d3_cmd_ready, 1'b1);
    check("d3_idle_valid", d3_rsp_valid, 1'b0);
    check("d3_acc",        d3_acc, 4'h2);
    check("d3_errcnt",     d3_err_count, 8'h00);
    $display("txn d3 op=2 a=1 b=1 -> out=%h flags=%b err=%0d", d3_rsp_out, d3_rsp_flags, d3_rsp_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
